// File: rtl/layer_address_sequencer.sv
// Address sequencer for one fully-connected layer pass.
// For each output neuron j it walks terms i = 0..T-1 (T = n_in + bias_en),
// presenting the weight/input/output addresses for every term on a
// valid/ready handshake, with a write strobe on the last term of a neuron.
//
// Ports:
//   clk, reset              clock, asynchronous active-low reset
//   start, abort            begin a pass (IDLE only), cancel a running pass
//   n_in, n_out, bias_en    layer shape, latched on the accepted start
//   w_base, x_base, y_base  weight / input-neuron / output-neuron bases
//   addr_ready              consumer accepts the current address set
//   addr_valid              address set valid (RUN)
//   w_addr, x_addr, y_addr  current addresses
//   first, last, is_bias    term flags for the current neuron
//   y_we                    output-neuron write strobe (combinational)
//   busy, done              pass in progress, one-cycle completion pulse
module layer_address_sequencer #(
  parameter int unsigned AW = 8,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] n_in,
  input  logic [CW-1:0] n_out,
  input  logic          bias_en,
  input  logic [AW-1:0] w_base,
  input  logic [AW-1:0] x_base,
  input  logic [AW-1:0] y_base,
  input  logic          addr_ready,
  output logic          addr_valid,
  output logic [AW-1:0] w_addr,
  output logic [AW-1:0] x_addr,
  output logic [AW-1:0] y_addr,
  output logic          first,
  output logic          last,
  output logic          is_bias,
  output logic          y_we,
  output logic          busy,
  output logic          done
);

  // Counters are one bit wider than the counts so n up to 2^CW-1 never overflows.
  localparam int unsigned TW = CW + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q,   state_d;
  logic [CW-1:0] n_in_q,    n_in_d;
  logic [CW-1:0] n_out_q,   n_out_d;
  logic          bias_q,    bias_d;
  logic [AW-1:0] w_base_q,  w_base_d;
  logic [AW-1:0] x_base_q,  x_base_d;
  logic [AW-1:0] y_base_q,  y_base_d;
  logic [TW-1:0] i_q,       i_d;
  logic [TW-1:0] j_q,       j_d;
  logic [AW-1:0] k_q,       k_d;
  logic [AW-1:0] w_addr_q,  w_addr_d;
  logic [AW-1:0] x_addr_q,  x_addr_d;
  logic [AW-1:0] y_addr_q,  y_addr_d;
  logic          first_q,   first_d;
  logic          last_q,    last_d;
  logic          is_bias_q, is_bias_d;

  logic          in_run;
  logic          xfer;
  logic          accept;
  logic [TW-1:0] t_in;
  logic [TW-1:0] t_d;

  // Handshake qualifiers; abort wins over a simultaneous transfer.
  assign in_run = (state_q == RUN);
  assign xfer   = in_run & addr_ready & ~abort;
  assign accept = (state_q == IDLE) & start;
  assign t_in   = TW'(n_in) + TW'(bias_en);

  // Next-state, counter and output-register computation.
  always_comb begin
    state_d   = state_q;
    n_in_d    = n_in_q;
    n_out_d   = n_out_q;
    bias_d    = bias_q;
    w_base_d  = w_base_q;
    x_base_d  = x_base_q;
    y_base_d  = y_base_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    w_addr_d  = w_addr_q;
    x_addr_d  = x_addr_q;
    y_addr_d  = y_addr_q;
    first_d   = first_q;
    last_d    = last_q;
    is_bias_d = is_bias_q;
    t_d       = TW'(0);

    case (state_q)
      IDLE: begin
        if (start) begin
          n_in_d   = n_in;
          n_out_d  = n_out;
          bias_d   = bias_en;
          w_base_d = w_base;
          x_base_d = x_base;
          y_base_d = y_base;
          i_d      = TW'(0);
          j_d      = TW'(0);
          k_d      = AW'(0);
          // An empty pass skips RUN entirely but still reports completion.
          if ((t_in == TW'(0)) || (n_out == CW'(0))) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (addr_ready) begin
          k_d = k_q + AW'(1);
          if (last_q) begin
            i_d = TW'(0);
            j_d = j_q + TW'(1);
            if (j_q == (TW'(n_out_q) - TW'(1))) begin
              state_d = DONE;
            end
          end else begin
            i_d = i_q + TW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered copies of base + counter, refreshed only when
    // the counters move, so they hold through stalls and after a pass.
    if (accept || xfer) begin
      t_d       = TW'(n_in_d) + TW'(bias_d);
      w_addr_d  = w_base_d + k_d;
      x_addr_d  = x_base_d + AW'(i_d);
      y_addr_d  = y_base_d + AW'(j_d);
      first_d   = (i_d == TW'(0));
      last_d    = (i_d == (t_d - TW'(1)));
      is_bias_d = bias_d & (i_d == TW'(n_in_d));
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      n_in_q    <= '0;
      n_out_q   <= '0;
      bias_q    <= 1'b0;
      w_base_q  <= '0;
      x_base_q  <= '0;
      y_base_q  <= '0;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      w_addr_q  <= '0;
      x_addr_q  <= '0;
      y_addr_q  <= '0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      is_bias_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_in_q    <= n_in_d;
      n_out_q   <= n_out_d;
      bias_q    <= bias_d;
      w_base_q  <= w_base_d;
      x_base_q  <= x_base_d;
      y_base_q  <= y_base_d;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      w_addr_q  <= w_addr_d;
      x_addr_q  <= x_addr_d;
      y_addr_q  <= y_addr_d;
      first_q   <= first_d;
      last_q    <= last_d;
      is_bias_q <= is_bias_d;
    end
  end

  assign addr_valid = in_run;
  assign busy       = in_run;
  assign done       = (state_q == DONE);
  assign w_addr     = w_addr_q;
  assign x_addr     = x_addr_q;
  assign y_addr     = y_addr_q;
  assign first      = first_q;
  assign last       = last_q;
  assign is_bias    = is_bias_q;
  // Write strobe accompanies the final term of a neuron in the same cycle.
  assign y_we       = xfer & last_q;

endmodule

// File: tb/tb_layer_address_sequencer.sv
// Scoreboard bench for layer_address_sequencer: directed passes push their
// hand-computed address sets into a queue; a monitor pops and compares on
// every transfer and checks held outputs on stall cycles.
module tb_layer_address_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, abort, bias_en, addr_ready;
  logic [7:0] n_in, n_out, w_base, x_base, y_base;
  logic       addr_valid, first, last, is_bias, y_we, busy, done;
  logic [7:0] w_addr, x_addr, y_addr;

  typedef struct packed {
    logic [7:0] w;
    logic [7:0] x;
    logic [7:0] y;
    logic       f;
    logic       l;
    logic       b;
    logic       we;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   last_xfer_cyc = -10;

  layer_address_sequencer #(.AW(8), .CW(8)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .n_in(n_in), .n_out(n_out), .bias_en(bias_en),
    .w_base(w_base), .x_base(x_base), .y_base(y_base),
    .addr_ready(addr_ready), .addr_valid(addr_valid),
    .w_addr(w_addr), .x_addr(x_addr), .y_addr(y_addr),
    .first(first), .last(last), .is_bias(is_bias), .y_we(y_we),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] w, x, y, input logic f, l, b, we);
    exp_t e;
    e.w = w; e.x = x; e.y = y; e.f = f; e.l = l; e.b = b; e.we = we;
    exp_q.push_back(e);
  endtask

  // n_in=3, n_out=2, no bias, bases 0x10/0x40/0x80.
  task automatic push_basic();
    push(8'h10, 8'h40, 8'h80, 1, 0, 0, 0);
    push(8'h11, 8'h41, 8'h80, 0, 0, 0, 0);
    push(8'h12, 8'h42, 8'h80, 0, 1, 0, 1);
    push(8'h13, 8'h40, 8'h81, 1, 0, 0, 0);
    push(8'h14, 8'h41, 8'h81, 0, 0, 0, 0);
    push(8'h15, 8'h42, 8'h81, 0, 1, 0, 1);
  endtask

  // Monitor: pop on transfer, compare against queue head on stall.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (addr_valid && addr_ready && !abort) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_xfer: got w=%0h x=%0h y=%0h with empty queue", w_addr, x_addr, y_addr);
      end else begin
        e = exp_q.pop_front();
        check("w_addr", 32'(w_addr), 32'(e.w));
        check("x_addr", 32'(x_addr), 32'(e.x));
        check("y_addr", 32'(y_addr), 32'(e.y));
        check("first", 32'(first), 32'(e.f));
        check("last", 32'(last), 32'(e.l));
        check("is_bias", 32'(is_bias), 32'(e.b));
        check("y_we", 32'(y_we), 32'(e.we));
        last_xfer_cyc = cyc;
      end
    end else if (addr_valid && !addr_ready && exp_q.size() != 0) begin
      e = exp_q[0];
      check("stall_w_addr", 32'(w_addr), 32'(e.w));
      check("stall_x_addr", 32'(x_addr), 32'(e.x));
      check("stall_y_addr", 32'(y_addr), 32'(e.y));
      check("stall_last", 32'(last), 32'(e.l));
      check("stall_y_we", 32'(y_we), 32'd0);
    end
  end

  // Called at posedge+#1 in IDLE; returns at posedge+#1 after start was sampled.
  // Config is scrambled afterwards, which must not disturb the pass.
  task automatic do_start(input logic [7:0] ni, no, input logic b, input logic [7:0] wb, xb, yb);
    n_in = ni; n_out = no; bias_en = b;
    w_base = wb; x_base = xb; y_base = yb;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_in = 8'hA5; n_out = 8'h5A; bias_en = ~b;
    w_base = 8'hC3; x_base = 8'h3C; y_base = 8'h99;
  endtask

  // mode 0: addr_ready held 1; mode 1: addr_ready pattern 1,0,0,1.
  task automatic run_until_done(input string name, input int mode, input bit chk_lat);
    logic pat [4];
    bit   seen = 1'b0;
    int   lc = 0;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    while (lc < 400 && !seen) begin
      addr_ready = (mode == 0) ? 1'b1 : pat[lc % 4];
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        check({name, "_done_valid"}, 32'(addr_valid), 32'd0);
        if (chk_lat) check({name, "_done_latency"}, 32'(cyc), 32'(last_xfer_cyc + 1));
      end
      @(posedge clk); #1;
      lc++;
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check({name, "_done_one_cycle"}, 32'(done), 32'd0);
    check({name, "_idle_busy"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; addr_ready = 1'b0;
    n_in = '0; n_out = '0; bias_en = 1'b0;
    w_base = '0; x_base = '0; y_base = '0;

    // Reset values.
    #12;
    check("rst_valid", 32'(addr_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_flags", 32'({first, last, is_bias, y_we}), 32'd0);
    check("rst_addrs", 32'({w_addr, x_addr, y_addr}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Basic pass.
    push_basic();
    do_start(8'd3, 8'd2, 1'b0, 8'h10, 8'h40, 8'h80);
    run_until_done("basic", 0, 1'b1);

    // Bias term per neuron.
    push(8'h10, 8'h40, 8'h80, 1, 0, 0, 0);
    push(8'h11, 8'h41, 8'h80, 0, 0, 0, 0);
    push(8'h12, 8'h42, 8'h80, 0, 0, 0, 0);
    push(8'h13, 8'h43, 8'h80, 0, 1, 1, 1);
    push(8'h14, 8'h40, 8'h81, 1, 0, 0, 0);
    push(8'h15, 8'h41, 8'h81, 0, 0, 0, 0);
    push(8'h16, 8'h42, 8'h81, 0, 0, 0, 0);
    push(8'h17, 8'h43, 8'h81, 0, 1, 1, 1);
    do_start(8'd3, 8'd2, 1'b1, 8'h10, 8'h40, 8'h80);
    run_until_done("bias", 0, 1'b1);

    // Backpressure.
    push_basic();
    do_start(8'd3, 8'd2, 1'b0, 8'h10, 8'h40, 8'h80);
    run_until_done("stall", 1, 1'b1);

    // Empty layer: done immediately, never valid.
    do_start(8'd3, 8'd0, 1'b0, 8'h10, 8'h40, 8'h80);
    check("nout0_done_next", 32'(done), 32'd1);
    check("nout0_valid", 32'(addr_valid), 32'd0);
    run_until_done("nout0", 0, 1'b0);

    // Bias only: one term per neuron.
    push(8'h10, 8'h40, 8'h80, 1, 1, 1, 1);
    push(8'h11, 8'h40, 8'h81, 1, 1, 1, 1);
    do_start(8'd0, 8'd2, 1'b1, 8'h10, 8'h40, 8'h80);
    run_until_done("bias_only", 0, 1'b1);

    // Weight address wrap.
    push(8'hFE, 8'h40, 8'h80, 1, 0, 0, 0);
    push(8'hFF, 8'h41, 8'h80, 0, 0, 0, 0);
    push(8'h00, 8'h42, 8'h80, 0, 0, 0, 0);
    push(8'h01, 8'h43, 8'h80, 0, 1, 0, 1);
    do_start(8'd4, 8'd1, 1'b0, 8'hFE, 8'h40, 8'h80);
    run_until_done("wrap", 0, 1'b1);

    // Abort on transfer 2 (which would have been a last term).
    addr_ready = 1'b1;
    push(8'h10, 8'h40, 8'h80, 1, 0, 0, 0);
    do_start(8'd2, 8'd2, 1'b0, 8'h10, 8'h40, 8'h80);
    @(negedge clk);
    @(posedge clk); #1;
    abort = 1'b1;
    @(negedge clk);
    check("abort_y_we", 32'(y_we), 32'd0);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_idle", 32'(busy), 32'd0);
    check("abort_no_done", 32'(done), 32'd0);
    check("abort_queue", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("abort_no_done2", 32'(done), 32'd0);
    @(posedge clk); #1;
    push_basic();
    do_start(8'd3, 8'd2, 1'b0, 8'h10, 8'h40, 8'h80);
    run_until_done("after_abort", 0, 1'b1);

    // Reset mid-pass.
    addr_ready = 1'b1;
    push(8'h10, 8'h40, 8'h80, 1, 0, 0, 0);
    do_start(8'd2, 8'd2, 1'b0, 8'h10, 8'h40, 8'h80);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(addr_valid), 32'd0);
    check("mid_rst_y_we", 32'(y_we), 32'd0);
    check("mid_rst_addrs", 32'({w_addr, x_addr, y_addr}), 32'd0);
    check("mid_rst_flags", 32'({first, last, is_bias}), 32'd0);
    @(negedge clk);
    check("mid_rst_no_done", 32'(done), 32'd0);
    check("mid_rst_queue", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    push_basic();
    do_start(8'd3, 8'd2, 1'b0, 8'h10, 8'h40, 8'h80);
    run_until_done("after_reset", 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
